// File: rtl/fp_pkg.sv
// Shared definitions for the packed-float encoder (FPCVT) and decoder (fp_decode_seq).
// A packed float {S,E,F} represents (-1)^S * F * 2^E.
package fp_pkg;

    localparam int D_W = 13;  // linear sample width, two's complement
    localparam int E_W = 3;   // exponent width, unsigned shift count
    localparam int F_W = 5;   // significand width, unsigned magnitude

    // Packed float as carried between FPCVT and its consumers
    typedef struct packed {
        logic           s;
        logic [E_W-1:0] e;
        logic [F_W-1:0] f;
    } fp_t;

    // Decoder sequencing states (2-bit encoding)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_SIGN  = 2'd2,
        ST_DONE  = 2'd3
    } dec_state_e;

endpackage

// File: rtl/fp_decode_seq.sv
// Iterative packed-float to two's-complement expander.
// Accepts {S,E,F} in IDLE, shifts the magnitude left once per clock E times,
// applies the sign in one extra cycle, then holds D/out_valid until accepted.
// With F_W + 2**E_W - 1 < D_W the shifted magnitude never reaches the top bit,
// so negation cannot overflow and no saturation path is needed.
module fp_decode_seq
    import fp_pkg::*;
#(
    parameter int D_W_P = D_W,
    parameter int E_W_P = E_W,
    parameter int F_W_P = F_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             S,
    input  logic [E_W_P-1:0] E,
    input  logic [F_W_P-1:0] F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W_P-1:0] D
);

    dec_state_e       state_q, state_d;
    logic [D_W_P-1:0] mag_q, mag_d;
    logic [E_W_P-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic [D_W_P-1:0] d_q, d_d;
    logic             out_valid_q, out_valid_d;

    // Input side is only open while idle; nothing else is looked at in other states.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign D         = d_q;

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mag_q       <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, shifter, down-counter and sign application.
    always_comb begin
        state_d     = state_q;
        mag_d       = mag_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d  = S;
                    cnt_d   = E;
                    mag_d   = {{(D_W_P-F_W_P){1'b0}}, F};
                    // E==0 needs no shifting at all
                    state_d = (E != '0) ? ST_SHIFT : ST_SIGN;
                end
            end
            ST_SHIFT: begin
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 1'b1;
                // Leaving on the count of one gives exactly E shifts
                if (cnt_q == E_W_P'(1)) begin
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                // A zero magnitude negates to zero, so there is no -0
                d_d         = sign_q ? (~mag_q + 1'b1) : mag_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                // D is left holding the last result after the handshake
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
